// File: rtl/scs8hd_lpflow_pwrseq_ctrl_if.sv
// Signal bundle between the power manager / header switch and the power-gating sequencer.
// master = environment (power manager + switch), slave = sequencer.
interface scs8hd_lpflow_pwrseq_ctrl_if;
  logic       sleep_req;
  logic       pwr_good;
  logic       sleep_ack;
  logic       iso_en;
  logic       save;
  logic       restore;
  logic       sw_en_b;
  logic       err;
  logic [2:0] state;

  modport master (
    output sleep_req, pwr_good,
    input  sleep_ack, iso_en, save, restore, sw_en_b, err, state
  );

  modport slave (
    input  sleep_req, pwr_good,
    output sleep_ack, iso_en, save, restore, sw_en_b, err, state
  );
endinterface

// File: rtl/scs8hd_lpflow_pwrseq_ctrl.sv
// Always-on sleep/wake sequencer: isolate, save, switch off, wait power-good, and the reverse.
// All outputs are registered and decoded from the next state so they line up with the state register.
module scs8hd_lpflow_pwrseq_ctrl #(
  parameter int ISO_DLY     = 2,
  parameter int SAVE_CYC    = 2,
  parameter int RESTORE_CYC = 2,
  parameter int SW_TIMEOUT  = 16,
  parameter int CNT_W       = 5
) (
  input  logic                        clk,
  input  logic                        reset_b,
  scs8hd_lpflow_pwrseq_ctrl_if.slave  pif
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_ISO     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_PWROFF  = 3'd3,
    ST_SLEEP   = 3'd4,
    ST_PWRON   = 3'd5,
    ST_RESTORE = 3'd6,
    ST_UNISO   = 3'd7
  } state_e;

  typedef struct packed {
    logic sleep_ack;
    logic iso_en;
    logic save;
    logic restore;
    logic sw_en_b;
  } outs_t;

  // Counter holds "cycles left minus one", so a state lasting N cycles loads N-1.
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] SAV_LD = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RESTORE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(SW_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  outs_t            outs_q, outs_d;
  logic [1:0]       pg_sync_q;
  logic             pg_s;
  logic             cnt_zero;

  // Synchronizer resets to "powered" to match the domain being on out of reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) pg_sync_q <= 2'b11;
    else          pg_sync_q <= {pg_sync_q[0], pif.pwr_good};
  end
  assign pg_s = pg_sync_q[1];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      outs_q  <= outs_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: if (pif.sleep_req) begin
        state_d = ST_ISO;
        cnt_d   = ISO_LD;
      end
      ST_ISO: if (cnt_zero) begin
        state_d = ST_SAVE;
        cnt_d   = SAV_LD;
      end else cnt_d = cnt_q - 1'b1;
      ST_SAVE: if (cnt_zero) begin
        state_d = ST_PWROFF;
        cnt_d   = TO_LD;
      end else cnt_d = cnt_q - 1'b1;
      // Power-good wins over an expiring timeout in the same cycle.
      ST_PWROFF: if (!pg_s) state_d = ST_SLEEP;
      else if (cnt_zero) begin
        state_d = ST_SLEEP;
        err_d   = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      ST_SLEEP: if (!pif.sleep_req) begin
        state_d = ST_PWRON;
        cnt_d   = TO_LD;
      end
      ST_PWRON: if (pg_s) begin
        state_d = ST_RESTORE;
        cnt_d   = RST_LD;
      end else if (cnt_zero) begin
        state_d = ST_RESTORE;
        cnt_d   = RST_LD;
        err_d   = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      ST_RESTORE: if (cnt_zero) state_d = ST_UNISO;
      else cnt_d = cnt_q - 1'b1;
      ST_UNISO: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    outs_d = '0;
    case (state_d)
      ST_ISO:     outs_d.iso_en = 1'b1;
      ST_SAVE:    begin outs_d.iso_en = 1'b1; outs_d.save = 1'b1; end
      ST_PWROFF:  begin outs_d.iso_en = 1'b1; outs_d.sw_en_b = 1'b1; end
      ST_SLEEP:   begin outs_d.iso_en = 1'b1; outs_d.sw_en_b = 1'b1; outs_d.sleep_ack = 1'b1; end
      ST_PWRON:   begin outs_d.iso_en = 1'b1; outs_d.sleep_ack = 1'b1; end
      ST_RESTORE: begin outs_d.iso_en = 1'b1; outs_d.restore = 1'b1; outs_d.sleep_ack = 1'b1; end
      ST_UNISO:   outs_d.sleep_ack = 1'b1;
      default:    outs_d = '0;
    endcase
  end

  assign pif.sleep_ack = outs_q.sleep_ack;
  assign pif.iso_en    = outs_q.iso_en;
  assign pif.save      = outs_q.save;
  assign pif.restore   = outs_q.restore;
  assign pif.sw_en_b   = outs_q.sw_en_b;
  assign pif.err       = err_q;
  assign pif.state     = state_q;

endmodule

// File: tb/tb_scs8hd_lpflow_pwrseq_ctrl.sv
// Randomized bench for the power-gating sequencer: stimulus pushes expected phase segments
// (state, length, err) into a scoreboard that a negedge monitor pops on every state change.
module tb_scs8hd_lpflow_pwrseq_ctrl;
  localparam int ISO_DLY = 2, SAVE_CYC = 2, RESTORE_CYC = 2, SW_TO = 16;
  localparam logic [2:0] S_RUN = 3'd0, S_ISO = 3'd1, S_SAVE = 3'd2, S_PWROFF = 3'd3,
                         S_SLEEP = 3'd4, S_PWRON = 3'd5, S_RESTORE = 3'd6, S_UNISO = 3'd7;

  typedef struct {
    logic [2:0] st;
    int         dur;   // 0 = length set by the environment, not checked
    logic       err;
  } seg_t;

  logic clk = 1'b0;
  logic reset_b;
  scs8hd_lpflow_pwrseq_ctrl_if pif();

  scs8hd_lpflow_pwrseq_ctrl #(
    .ISO_DLY(ISO_DLY), .SAVE_CYC(SAVE_CYC), .RESTORE_CYC(RESTORE_CYC),
    .SW_TIMEOUT(SW_TO), .CNT_W(5)
  ) dut (
    .clk(clk), .reset_b(reset_b), .pif(pif)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  seg_t sb[$];
  logic mon_en;
  logic stuck;
  int   d_off, d_on;
  logic err_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [5:0] outs_vec();
    return {pif.sleep_ack, pif.iso_en, pif.save, pif.restore, pif.sw_en_b, pif.err};
  endfunction

  // Output table per phase: {ack, iso, save, restore, sw_en_b, err}
  function automatic logic [5:0] exp_outs(input logic [2:0] st, input logic e);
    logic [4:0] o;
    case (st)
      S_ISO:     o = 5'b01000;
      S_SAVE:    o = 5'b01100;
      S_PWROFF:  o = 5'b01001;
      S_SLEEP:   o = 5'b11001;
      S_PWRON:   o = 5'b11000;
      S_RESTORE: o = 5'b11010;
      S_UNISO:   o = 5'b10000;
      default:   o = 5'b00000;
    endcase
    return {o, e};
  endfunction

  task automatic push(input logic [2:0] st, input int dur, input logic e);
    seg_t s;
    s.st = st; s.dur = dur; s.err = e;
    sb.push_back(s);
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int k = 0;
    while (pif.state !== s && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (k >= 64) begin
      n_chk++;
      $display("FAIL %s timeout actual_state=%0d expected_state=%0d", nm, pif.state, s);
    end
  endtask

  // Header switch model: pwr_good follows !sw_en_b after a programmable delay, or holds when stuck.
  initial begin
    int cnt = 0;
    pif.pwr_good = 1'b1;
    forever begin
      @(negedge clk);
      if (!stuck) begin
        if (pif.pwr_good != !pif.sw_en_b) begin
          if (cnt >= (pif.sw_en_b ? d_off : d_on)) begin
            pif.pwr_good = !pif.sw_en_b;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end
    end
  end

  // Monitor: pops a segment on each state change, checks the finished segment's length,
  // the per-cycle outputs of the current one, and the ordering invariants.
  initial begin
    seg_t cur;
    int   seg_cnt = 0;
    logic act = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) act = 1'b0;
      else begin
        if (!act) begin
          cur.st = S_RUN; cur.dur = 0; cur.err = 1'b0;
          seg_cnt = 0;
          act = 1'b1;
        end
        if (pif.state !== cur.st) begin
          if (cur.dur != 0) chk($sformatf("dur_st%0d", cur.st), seg_cnt, cur.dur);
          chk("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) cur = sb.pop_front();
          seg_cnt = 0;
          chk("state", pif.state, cur.st);
        end
        seg_cnt++;
        chk($sformatf("outs_st%0d", cur.st), outs_vec(), exp_outs(cur.st, cur.err));
        chk("inv_strobe_off", (pif.save | pif.restore) & (pif.sw_en_b | !pif.iso_en), 0);
        chk("inv_iso_sw", pif.sw_en_b & !pif.iso_en, 0);
        chk("inv_save_restore", pif.save & pif.restore, 0);
      end
    end
  end

  task automatic run_cycle(input int doff, input bit stk_off, input bit early, input int idle,
                           input int don, input bit stk_on, input bit reassert, input bit chained);
    logic pe;
    int   k;
    if (chained) wait_state(S_RESTORE, "to_restore");
    else begin
      wait_state(S_RUN, "to_run");
      stuck = 1'b0;
      k = 0;
      while (pif.pwr_good !== 1'b1 && k < 64) begin @(negedge clk); k++; end
      repeat (3 + idle) @(negedge clk);
    end
    d_off = doff; d_on = don; stuck = stk_off;
    pe = err_exp;
    push(S_ISO, ISO_DLY, pe);
    push(S_SAVE, SAVE_CYC, pe);
    push(S_PWROFF, stk_off ? SW_TO : doff + 3, pe);
    if (stk_off) err_exp = 1'b1;
    push(S_SLEEP, early ? 1 : 0, err_exp);
    pif.sleep_req = 1'b1;
    if (early) wait_state(S_SAVE, "to_save");
    else begin
      wait_state(S_SLEEP, "to_sleep");
      repeat (idle) @(negedge clk);
      if (stk_on) stuck = 1'b1;
    end
    pe = err_exp;
    push(S_PWRON, stk_off ? 1 : (stk_on ? SW_TO : don + 3), pe);
    if (stk_on) err_exp = 1'b1;
    push(S_RESTORE, RESTORE_CYC, err_exp);
    push(S_UNISO, 1, err_exp);
    push(S_RUN, reassert ? 1 : 0, err_exp);
    pif.sleep_req = 1'b0;
  endtask

  initial begin
    bit prev_re = 1'b0;
    pif.sleep_req = 1'b0;
    reset_b = 1'b0; mon_en = 1'b0; stuck = 1'b0;
    d_off = 1; d_on = 1; err_exp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", pif.state, S_RUN);
    chk("rst_outs", outs_vec(), 0);
    reset_b = 1'b1;
    @(negedge clk);
    pif.sleep_req = 1'b1;
    wait_state(S_SAVE, "rst_to_save");
    chk("pre_rst_save", pif.save, 1);
    #2 reset_b = 1'b0;
    #1;
    chk("mid_rst_state", pif.state, S_RUN);
    chk("mid_rst_outs", outs_vec(), 0);
    pif.sleep_req = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    run_cycle(1, 0, 0, 3, 1, 0, 0, 0);  // full sequence, fast switch
    run_cycle(2, 0, 1, 0, 2, 0, 0, 0);  // request dropped during SAVE
    run_cycle(0, 0, 0, 2, 3, 0, 1, 0);  // request reasserted during RESTORE
    run_cycle(1, 0, 0, 1, 1, 0, 0, 1);
    run_cycle(0, 1, 0, 2, 0, 0, 0, 0);  // pwr_good stuck high: PWROFF timeout
    run_cycle(2, 0, 0, 2, 2, 0, 0, 0);  // clean cycle, err stays set
    run_cycle(1, 0, 0, 1, 0, 1, 0, 0);  // pwr_good stuck low on wake: PWRON timeout

    for (int i = 0; i < 25; i++) begin
      int doff, don, idle;
      bit so, ea, sn, re;
      doff = $urandom_range(0, 8);
      don  = $urandom_range(0, 8);
      idle = $urandom_range(0, 4);
      so = ($urandom_range(0, 5) == 0);
      ea = !so && ($urandom_range(0, 3) == 0);
      sn = !so && !ea && ($urandom_range(0, 5) == 0);
      re = !so && !sn && ($urandom_range(0, 3) == 0);
      run_cycle(doff, so, ea, idle, don, sn, re, prev_re);
      prev_re = re;
    end

    wait_state(S_RUN, "final_run");
    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
